gray_monitor: RTL and testbench
===============================

// Module: gray_monitor
// PURPOSE
//  Downstream consumer of the gray-code counter. Samples the counter's gray output every Clk,
//  converts it to binary, checks every change is a legal +1 single-bit step, and counts
//  wrap-arounds (epochs). Feeds binary position and health flags to later logic.
// PARAMETERS
//  WIDTH    3  gray/binary code width
//  EPOCH_W  8  width of wrap-around (epoch) counter
//  ERR_W    8  width of error counter (GRAY_MON_ERRCNT_EN only)
// PORTS
//  Clk       in   1        system clock, rising edge
//  Reset     in   1        asynchronous, active-low reset
//  Gray      in   WIDTH    gray code from upstream counter, sampled every cycle
//  Binary    out  WIDTH    registered binary of last accepted sample
//  Epoch     out  EPOCH_W  number of wraps (all-ones -> zero) since lock, saturating
//  Locked    out  1        1 while tracking a legal sequence
//  Wrap      out  1        1-cycle pulse: accepted step all-ones -> zero
//  StepErr   out  1        1-cycle pulse: illegal transition detected
//  ErrCnt    out  ERR_W    saturating StepErr count (only with GRAY_MON_ERRCNT_EN)
// BEHAVIOUR
//  - Reset low (any time, async): state UNLOCKED; Binary=0, Epoch=0, Locked=0, Wrap=0,
//    StepErr=0, ErrCnt=0, reference sample=0. Reset mid-run discards all history.
//  - Conversion: b[WIDTH-1]=g[WIDTH-1]; b[i]=b[i+1]^g[i]. Outputs registered: latency 1 cycle
//    (Binary at edge t+1 reflects Gray sampled at edge t).
//  - States: UNLOCKED, LOCKED, FAULT.
//    UNLOCKED: first sample after reset release becomes reference; Binary updates; -> LOCKED.
//      No Wrap/StepErr in this cycle.
//    LOCKED: compare sample g vs reference r (binary bn, br):
//      g==r                          -> hold (upstream En low); outputs unchanged.
//      bn==(br+1) mod 2^WIDTH        -> accept; r<=g; Binary<=bn; if br all-ones and bn==0:
//                                       Wrap=1, Epoch+=1 (saturate at all-ones, no roll).
//      anything else (multi-bit, backward, skip) -> StepErr=1, Locked<=0, -> FAULT;
//                                       Binary/Epoch hold; reference not updated.
//    FAULT: next sample becomes new reference unconditionally; Binary updates; Epoch kept;
//      Locked<=1; -> LOCKED. FAULT lasts exactly one cycle.
//  - Locked=1 exactly when state is LOCKED. Wrap and StepErr never both 1.
//  - Only +1 steps are legal; a decrement by one (Hamming distance 1) is an error.
//  - All arithmetic modulo 2^WIDTH; Epoch/ErrCnt compare against all-ones before incrementing.
// CONFIGURATION
//  GRAY_MON_ERRCNT_EN defined: ErrCnt port present; increments on every StepErr pulse,
//    saturates at 2^ERR_W-1, cleared only by Reset.
//  Not defined: ErrCnt port and register absent; all other behaviour identical.
// STRUCTURE
//  Package gray_mon_pkg: state encoding constants S_UNLOCKED=2'd0, S_LOCKED=2'd1,
//    S_FAULT=2'd2; saturating-increment function.
//  Sub-module gray2bin (parameter WIDTH, purely combinational) instantiated once for Gray;
//    reference kept in binary so no second converter is needed.
//  Top holds FSM, reference register, Epoch/ErrCnt counters, pulse registers.
// TESTING
//  1 Reset low 3 cycles, Gray=101 -> all outputs 0, Locked=0; release -> next edge Locked=1, Binary=110.
//  2 WIDTH=3 free-run 000,001,011,010,110,111,101,100,000 -> Binary 0..7,0 one cycle later;
//    Wrap single pulse with Binary=0; Epoch=1; StepErr never.
//  3 Hold Gray=011 for 5 cycles mid-sequence -> Binary=2 steady, no pulses, Locked stays 1.
//  4 Jump 001->010 -> StepErr pulse, Locked=0 one cycle, then Locked=1, Binary=3;
//    backward 011->001 -> StepErr pulse likewise.
//  5 EPOCH_W=2, 5 full wraps -> Epoch 1,2,3,3,3; assert Reset mid-count -> Epoch=0 asynchronously.
//  6 GRAY_MON_ERRCNT_EN, ERR_W=2, 4 errors -> ErrCnt 1,2,3,3; without macro, elaborates with no ErrCnt.

Source files
------------

// File: rtl/gray_mon_pkg.sv
// +----------------------------------------------------------------------------+
// | gray_mon_pkg : shared state encoding and helpers for gray_monitor          |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

package gray_mon_pkg;

    typedef enum logic [1:0] {
        S_UNLOCKED = 2'd0,
        S_LOCKED   = 2'd1,
        S_FAULT    = 2'd2
    } state_t;

    // Increment that sticks at max instead of rolling over; callers cast to their width.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max);
        return (val == max) ? val : val + 32'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/gray_monitor_if.sv
// +----------------------------------------------------------------------------+
// | gray_monitor_if : gray input and status outputs of gray_monitor            |
// | ErrCnt exists only when GRAY_MON_ERRCNT_EN is defined. Revision: 1.0       |
// +----------------------------------------------------------------------------+
`default_nettype none

interface gray_monitor_if #(
    parameter int WIDTH   = 3,
    parameter int EPOCH_W = 8
`ifdef GRAY_MON_ERRCNT_EN
    ,
    parameter int ERR_W   = 8
`endif
);

    logic [WIDTH-1:0]   Gray;
    logic [WIDTH-1:0]   Binary;
    logic [EPOCH_W-1:0] Epoch;
    logic               Locked;
    logic               Wrap;
    logic               StepErr;
`ifdef GRAY_MON_ERRCNT_EN
    logic [ERR_W-1:0]   ErrCnt;
`endif

    modport master (
        output Gray,
        input  Binary, Epoch, Locked, Wrap, StepErr
`ifdef GRAY_MON_ERRCNT_EN
        ,
        input  ErrCnt
`endif
    );

    modport slave (
        input  Gray,
        output Binary, Epoch, Locked, Wrap, StepErr
`ifdef GRAY_MON_ERRCNT_EN
        ,
        output ErrCnt
`endif
    );

endinterface

`default_nettype wire

// File: rtl/gray2bin.sv
// +----------------------------------------------------------------------------+
// | gray2bin : combinational gray-to-binary converter                          |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module gray2bin #(
    parameter int WIDTH = 3
) (
    input  wire logic [WIDTH-1:0] gray_i,
    output logic      [WIDTH-1:0] bin_o
);

    // Each binary bit is the XOR of all gray bits at or above it.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign bin_o[i] = ^gray_i[WIDTH-1:i];
    end

endmodule

`default_nettype wire

// File: rtl/gray_monitor.sv
// +----------------------------------------------------------------------------+
// | gray_monitor : tracks an upstream gray counter, flags illegal steps, counts|
// | wraps. GRAY_MON_ERRCNT_EN adds a saturating error counter. Revision: 1.0   |
// +----------------------------------------------------------------------------+
`default_nettype none

module gray_monitor
    import gray_mon_pkg::*;
#(
    parameter int WIDTH   = 3,
    parameter int EPOCH_W = 8
`ifdef GRAY_MON_ERRCNT_EN
    ,
    parameter int ERR_W   = 8
`endif
) (
    input  wire logic     Clk,
    input  wire logic     Reset,
    gray_monitor_if.slave bus
);

    localparam logic [WIDTH-1:0]   c_ONE       = WIDTH'(1);
    localparam logic [WIDTH-1:0]   c_ALL_ONES  = '1;
    localparam logic [EPOCH_W-1:0] c_EPOCH_MAX = '1;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   ref_q, ref_d;
    logic [WIDTH-1:0]   bin_q, bin_d;
    logic [EPOCH_W-1:0] epoch_q, epoch_d;
    logic               wrap_q, wrap_d;
    logic               err_q, err_d;
    logic [WIDTH-1:0]   sample_bin;

    // Reference is held in binary so the +1 check needs only this one converter.
    gray2bin #(.WIDTH(WIDTH)) u_gray2bin (
        .gray_i (bus.Gray),
        .bin_o  (sample_bin)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_UNLOCKED;
            ref_q   <= '0;
            bin_q   <= '0;
            epoch_q <= '0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ref_q   <= ref_d;
            bin_q   <= bin_d;
            epoch_q <= epoch_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ref_d   = ref_q;
        bin_d   = bin_q;
        epoch_d = epoch_q;
        wrap_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_UNLOCKED, S_FAULT: begin
                ref_d   = sample_bin;
                bin_d   = sample_bin;
                state_d = S_LOCKED;
            end
            S_LOCKED: begin
                if (sample_bin != ref_q) begin
                    if (sample_bin == ref_q + c_ONE) begin
                        ref_d = sample_bin;
                        bin_d = sample_bin;
                        if (ref_q == c_ALL_ONES) begin
                            wrap_d  = 1'b1;
                            epoch_d = EPOCH_W'(sat_inc(32'(epoch_q), 32'(c_EPOCH_MAX)));
                        end
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_FAULT;
                    end
                end
            end
            default: state_d = S_UNLOCKED;
        endcase
    end

    assign bus.Binary  = bin_q;
    assign bus.Epoch   = epoch_q;
    assign bus.Locked  = (state_q == S_LOCKED);
    assign bus.Wrap    = wrap_q;
    assign bus.StepErr = err_q;

`ifdef GRAY_MON_ERRCNT_EN
    localparam logic [ERR_W-1:0] c_ERR_MAX = '1;

    logic [ERR_W-1:0] errcnt_q, errcnt_d;

    always_comb begin
        errcnt_d = errcnt_q;
        if (err_d) begin
            errcnt_d = ERR_W'(sat_inc(32'(errcnt_q), 32'(c_ERR_MAX)));
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            errcnt_q <= '0;
        end else begin
            errcnt_q <= errcnt_d;
        end
    end

    assign bus.ErrCnt = errcnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gray_monitor.sv
// +----------------------------------------------------------------------------+
// | tb_gray_monitor : directed scoreboard bench for gray_monitor (W=3, E=2)    |
// | Revision        : 1.0                                                      |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_gray_monitor;

    localparam int WIDTH   = 3;
    localparam int EPOCH_W = 2;
    localparam int ERR_W   = 2;

    typedef struct packed {
        logic [2:0] bin;
        logic [1:0] ep;
        logic       lk;
        logic       wr;
        logic       er;
        logic [1:0] ec;
    } exp_t;

    logic Clk = 1'b0;
    logic Reset;
    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;

    logic [2:0] gtab   [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
    logic [1:0] ep_tab [4] = '{2'd2, 2'd3, 2'd3, 2'd3};

    gray_monitor_if #(
        .WIDTH   (WIDTH),
        .EPOCH_W (EPOCH_W)
`ifdef GRAY_MON_ERRCNT_EN
        ,
        .ERR_W   (ERR_W)
`endif
    ) bus ();

    gray_monitor #(
        .WIDTH   (WIDTH),
        .EPOCH_W (EPOCH_W)
`ifdef GRAY_MON_ERRCNT_EN
        ,
        .ERR_W   (ERR_W)
`endif
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    function automatic exp_t sample();
        exp_t a;
        a     = '0;
        a.bin = bus.Binary;
        a.ep  = bus.Epoch;
        a.lk  = bus.Locked;
        a.wr  = bus.Wrap;
        a.er  = bus.StepErr;
`ifdef GRAY_MON_ERRCNT_EN
        a.ec  = bus.ErrCnt;
`endif
        return a;
    endfunction

    task automatic check(input string name, input exp_t a, input exp_t e);
        bit ok;
        ok = (a.bin === e.bin) && (a.ep === e.ep) && (a.lk === e.lk) &&
             (a.wr === e.wr) && (a.er === e.er);
`ifdef GRAY_MON_ERRCNT_EN
        ok = ok && (a.ec === e.ec);
`endif
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got bin=%0d ep=%0d lk=%0b wr=%0b er=%0b ec=%0d, expected bin=%0d ep=%0d lk=%0b wr=%0b er=%0b ec=%0d",
                     name, a.bin, a.ep, a.lk, a.wr, a.er, a.ec, e.bin, e.ep, e.lk, e.wr, e.er, e.ec);
        end
    endtask

    // Present one gray sample and queue the outputs expected after the next edge.
    task automatic drive(input logic [2:0] g, input logic rn, input logic [2:0] b,
                         input logic [1:0] ep, input logic lk, input logic wr,
                         input logic er, input logic [1:0] ec);
        @(negedge Clk);
        bus.Gray = g;
        Reset    = rn;
        sb_q.push_back({b, ep, lk, wr, er, ec});
    endtask

    task automatic async_reset();
        @(posedge Clk);
        #3;
        Reset = 1'b0;
        #1;
        check("async_reset", sample(), '0);
    endtask

    // Monitor: compares one queued expectation per clock edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge Clk);
            #1;
            cycle++;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check($sformatf("cycle%0d", cycle), sample(), e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1);
    end

    initial begin
        logic [1:0] ep_prev;
        Reset    = 1'b0;
        bus.Gray = 3'b101;

        repeat (3) drive(3'b101, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0);
        drive(3'b101, 1'b1, 3'd6, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0);
        drive(3'b100, 1'b1, 3'd7, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0);
        drive(3'b000, 1'b1, 3'd0, 2'd1, 1'b1, 1'b1, 1'b0, 2'd0);

        async_reset();
        drive(3'b000, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0);
        drive(3'b000, 1'b1, 3'd0, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0);

        drive(3'b001, 1'b1, 3'd1, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0);
        drive(3'b011, 1'b1, 3'd2, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0);
        repeat (5) drive(3'b011, 1'b1, 3'd2, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0);
        drive(3'b010, 1'b1, 3'd3, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0);
        drive(3'b110, 1'b1, 3'd4, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0);
        drive(3'b111, 1'b1, 3'd5, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0);
        drive(3'b101, 1'b1, 3'd6, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0);
        drive(3'b100, 1'b1, 3'd7, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0);
        drive(3'b000, 1'b1, 3'd0, 2'd1, 1'b1, 1'b1, 1'b0, 2'd0);

        ep_prev = 2'd1;
        for (int w = 0; w < 4; w++) begin
            for (int i = 1; i < 8; i++) begin
                drive(gtab[i], 1'b1, 3'(i), ep_prev, 1'b1, 1'b0, 1'b0, 2'd0);
            end
            drive(3'b000, 1'b1, 3'd0, ep_tab[w], 1'b1, 1'b1, 1'b0, 2'd0);
            ep_prev = ep_tab[w];
        end

        async_reset();
        drive(3'b000, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0);
        drive(3'b000, 1'b1, 3'd0, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0);

        drive(3'b001, 1'b1, 3'd1, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0);
        drive(3'b010, 1'b1, 3'd1, 2'd0, 1'b0, 1'b0, 1'b1, 2'd1);
        drive(3'b010, 1'b1, 3'd3, 2'd0, 1'b1, 1'b0, 1'b0, 2'd1);
        drive(3'b110, 1'b1, 3'd4, 2'd0, 1'b1, 1'b0, 1'b0, 2'd1);
        drive(3'b010, 1'b1, 3'd4, 2'd0, 1'b0, 1'b0, 1'b1, 2'd2);
        drive(3'b010, 1'b1, 3'd3, 2'd0, 1'b1, 1'b0, 1'b0, 2'd2);
        drive(3'b111, 1'b1, 3'd3, 2'd0, 1'b0, 1'b0, 1'b1, 2'd3);
        drive(3'b101, 1'b1, 3'd6, 2'd0, 1'b1, 1'b0, 1'b0, 2'd3);
        drive(3'b100, 1'b1, 3'd7, 2'd0, 1'b1, 1'b0, 1'b0, 2'd3);
        drive(3'b000, 1'b1, 3'd0, 2'd1, 1'b1, 1'b1, 1'b0, 2'd3);
        drive(3'b000, 1'b1, 3'd0, 2'd1, 1'b1, 1'b0, 1'b0, 2'd3);
        drive(3'b011, 1'b1, 3'd0, 2'd1, 1'b0, 1'b0, 1'b1, 2'd3);
        drive(3'b011, 1'b1, 3'd2, 2'd1, 1'b1, 1'b0, 1'b0, 2'd3);

        repeat (3) @(negedge Clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
